spi_slave_4byte: RTL

SPI slave (responder) for the 4-byte SPI master link. Oversamples SPI_CLK, SPI_SS and MOSI on the fabric clock, assembles a C-bit word from MOSI and shifts a preloaded C-bit word out on MISO. Bit ordering matches the master: the master sends MOSI LSB-first and captures MISO MSB-first, so this block sends MISO MSB-first. Sits on the FPGA side of an inter-board link and hands received words to local logic with a one-cycle valid strobe.

---
 rtl/spi_slave_4byte.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/spi_slave_4byte.sv
// spi_slave_4byte
//   SPI responder for the 4-byte inter-board link. SPI_CLK, SPI_SS and MOSI
//   are oversampled on CLK_IN. A C-bit word is assembled LSB-first from MOSI,
//   and a preloaded C-bit word is shifted out MSB-first on MISO.
//
// Ports
//   CLK_IN     fabric clock (>= 4x SPI_CLK)
//   RST_N      asynchronous active-low reset
//   SPI_CLK    serial clock from master
//   SPI_SS     active-low slave select
//   MOSI       serial data from master
//   MISO       serial data to master (0 outside an active frame)
//   CPOL/CPHA  SPI mode, latched at frame start
//   tx_data    word to send in the next frame
//   tx_load    write tx_data into tx_buf this cycle
//   rx_data    last complete received word
//   rx_valid   one-cycle strobe when rx_data updates
//   frame_err  one-cycle strobe when SS rises before C bits were sampled
//   busy       frame in progress
module spi_slave_4byte #(
  parameter int C    = 32,
  parameter int SYNC = 2
) (
  input  logic         CLK_IN,
  input  logic         RST_N,
  input  logic         SPI_CLK,
  input  logic         SPI_SS,
  input  logic         MOSI,
  output logic         MISO,
  input  logic         CPOL,
  input  logic         CPHA,
  input  logic [C-1:0] tx_data,
  input  logic         tx_load,
  output logic [C-1:0] rx_data,
  output logic         rx_valid,
  output logic         frame_err,
  output logic         busy
);

  localparam int CW = $clog2(C + 1);
  localparam logic [CW-1:0] LAST = CW'(C - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t          state;
  logic [SYNC-1:0] ss_sync, sclk_sync, mosi_sync;
  logic            ss_d, sclk_d;
  logic            cpol_l, cpha_l;
  logic            lead_seen;
  logic [C-1:0]    tx_buf, shift_tx, rx_shift;
  logic [CW-1:0]   bit_cnt;

  // SS idles high and SCLK low through reset, so releasing reset never
  // looks like a frame start or a clock edge.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC-2:0], SPI_SS};
      sclk_sync <= {sclk_sync[SYNC-2:0], SPI_CLK};
      mosi_sync <= {mosi_sync[SYNC-2:0], MOSI};
      ss_d      <= ss_sync[SYNC-1];
      sclk_d    <= sclk_sync[SYNC-1];
    end
  end

  logic ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic lead, trail, sample_e, shift_e;
  logic [C-1:0] rx_next;

  assign ss_s      = ss_sync[SYNC-1];
  assign sclk_s    = sclk_sync[SYNC-1];
  assign mosi_s    = mosi_sync[SYNC-1];
  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  // Edges of sclk_e = sclk ^ CPOL_l, derived from the raw edges so that a
  // change of CPOL_l itself never produces a phantom edge.
  assign lead     = cpol_l ? sclk_fall : sclk_rise;
  assign trail    = cpol_l ? sclk_rise : sclk_fall;
  assign sample_e = cpha_l ? trail : lead;
  // In CPHA=1 the MSB is already on MISO, so the first leading edge is skipped.
  assign shift_e  = cpha_l ? (lead & lead_seen) : trail;
  // MOSI is synchronized alongside SCLK, so mosi_s is the value at the edge.
  assign rx_next  = {mosi_s, rx_shift[C-1:1]};

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      tx_buf    <= '0;
      shift_tx  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      bit_cnt   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      cpol_l    <= 1'b0;
      cpha_l    <= 1'b0;
      lead_seen <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (tx_load) tx_buf <= tx_data;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            cpol_l    <= CPOL;
            cpha_l    <= CPHA;
            // a load coinciding with frame start goes into this frame
            shift_tx  <= tx_load ? tx_data : tx_buf;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            lead_seen <= 1'b0;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (lead)    lead_seen <= 1'b1;
          if (shift_e) shift_tx  <= {shift_tx[C-2:0], 1'b0};
          if (sample_e) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 1'b1;
          end
          // completion wins over a simultaneous SS release
          if (sample_e && bit_cnt == LAST) begin
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
            state    <= ss_rise ? IDLE : DONE;
          end else if (ss_rise) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        DONE: begin
          if (ss_rise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MISO = (state == ACTIVE) & shift_tx[C-1];
  assign busy = (state != IDLE);

endmodule
